// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, FSM state
// encoding and a small opcode classification helper.
package alu_pkg;

  // 4-bit opcode space; values 10..15 are unassigned and produce a zero result.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  // IDLE: nothing held, BUSY: iterative shift running, DONE: result presented.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the opcodes handled by the one-bit-per-cycle shifter.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/add_sub_nbit.sv
// Combinational WIDTH-bit adder/subtractor with carry/borrow-in.
// Subtraction is a + ~b + ~cin, so the raw carry is the inverse of the borrow.
module add_sub_nbit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,   // carry-in (add) or borrow-in (sub)
  input  logic             sub_i,   // 1 selects a - b - cin
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,  // carry-out (add) or borrow-out (sub)
  output logic             ovf_o    // signed overflow
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   total;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign c_eff = sub_i ? ~cin_i : cin_i;
  assign total = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};

  assign sum_o  = total[WIDTH-1:0];
  assign cout_o = sub_i ? ~total[WIDTH] : total[WIDTH];

  // Overflow: operands of the effective same sign give a result of the other sign.
  always_comb begin
    if (sub_i) begin
      ovf_o = (a_i[MSB] != b_i[MSB]) && (sum_o[MSB] != a_i[MSB]);
    end else begin
      ovf_o = (a_i[MSB] == b_i[MSB]) && (sum_o[MSB] != a_i[MSB]);
    end
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// Sequential ALU behind a valid/ready handshake. Arithmetic and logic ops
// finish in one cycle; shifts iterate one bit per cycle. Result and flags are
// registered and only change when the FSM enters DONE.
module alu_seq_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  // Registered state
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;         // shift working register
  logic [SHW-1:0]   cnt_q, cnt_d;       // remaining shift steps
  logic [3:0]       sop_q, sop_d;       // captured shift opcode
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  // Combinational helpers
  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             start_busy;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic [WIDTH-1:0] sll_step;
  logic [WIDTH-1:0] srl_step;
  logic [WIDTH-1:0] step_val;
  logic             step_out;
  logic             load_en;
  logic [WIDTH-1:0] load_res;
  logic             load_cout;
  logic             load_ovf;

  assign shamt      = b[SHW-1:0];
  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign start_busy = is_shift(op) && (shamt != '0);

  // Single shared adder; the subtract control comes straight from the opcode.
  add_sub_nbit #(
    .WIDTH(WIDTH)
  ) u_add_sub (
    .a_i   (a),
    .b_i   (b),
    .cin_i (cin),
    .sub_i (op == OP_SUB),
    .sum_o (as_sum),
    .cout_o(as_cout),
    .ovf_o (as_ovf)
  );

  // One-bit shift step of the working register, built bit by bit.
  // SRA refills the top bit with itself, which keeps the original sign.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_step
      if (gi == 0) begin : g_lsb
        assign sll_step[gi] = 1'b0;
      end else begin : g_upper
        assign sll_step[gi] = sh_q[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign srl_step[gi] = (sop_q == OP_SRA) ? sh_q[WIDTH-1] : 1'b0;
      end else begin : g_lower
        assign srl_step[gi] = sh_q[gi+1];
      end
    end
  endgenerate

  // Pick the step direction and the bit that falls off the end.
  always_comb begin
    step_val = srl_step;
    step_out = sh_q[0];
    if (sop_q == OP_SLL) begin
      step_val = sll_step;
      step_out = sh_q[WIDTH-1];
    end
  end

  // Single-cycle result for the accepted op; a zero-amount shift passes a through.
  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res  = as_sum;
        alu_cout = as_cout;
        alu_ovf  = as_ovf;
      end
      OP_AND:                 alu_res = a & b;
      OP_OR:                  alu_res = a | b;
      OP_XOR:                 alu_res = a ^ b;
      OP_NOR:                 alu_res = ~(a | b);
      OP_NOT:                 alu_res = ~a;
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      default:                alu_res = '0;
    endcase
  end

  // Next-state logic: handshake, shift iteration and output loading.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    sop_d     = sop_q;
    load_en   = 1'b0;
    load_res  = alu_res;
    load_cout = alu_cout;
    load_ovf  = alu_ovf;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (start_busy) begin
            state_d = ST_BUSY;
            sh_d    = a;
            cnt_d   = shamt;
            sop_d   = op;
          end else begin
            state_d = ST_DONE;
            load_en = 1'b1;
          end
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        sh_d  = step_val;
        cnt_d = cnt_q - CNT_ONE;
        // The last step lands directly in the output registers.
        if (cnt_q == CNT_ONE) begin
          state_d   = ST_DONE;
          load_en   = 1'b1;
          load_res  = step_val;
          load_cout = step_out;
          load_ovf  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs only move on entering DONE, so nothing flickers during BUSY.
    result_d = load_en ? load_res : result_q;
    cout_d   = load_en ? load_cout : cout_q;
    ovf_d    = load_en ? load_ovf : ovf_q;
    zero_d   = load_en ? (load_res == '0) : zero_q;
    neg_d    = load_en ? load_res[WIDTH-1] : neg_q;
  end

  // State and output registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      sop_q    <= OP_ADD;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Self-checking bench for alu_seq_nbit: a 32-bit instance driven from a
// vector table with a scoreboard queue, hand-written handshake sequences,
// and an 8-bit instance for the narrow-width corner cases.
module tb_alu_seq_nbit;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  logic        cin, cout, zero, neg, ovf;

  logic        in_valid8, in_ready8, out_valid8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, result8;
  logic        cin8, cout8, zero8, neg8, ovf8;

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[$];

  alu_seq_nbit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  alu_seq_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(1'b1),
    .result(result8), .cout(cout8), .zero(zero8), .neg(neg8), .ovf(ovf8)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  // Scoreboard side: every result handed to the consumer is compared in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got res=%h with no request outstanding", result);
      end else begin
        mon_e = exp_q.pop_front();
        xfers++;
        if ({result, cout, zero, neg, ovf} !== mon_e) begin
          errors++;
          $display("FAIL xfer%0d: got res=%h c=%b z=%b n=%b v=%b expected res=%h c=%b z=%b n=%b v=%b",
                   xfers, result, cout, zero, neg, ovf,
                   mon_e.res, mon_e.c, mon_e.z, mon_e.n, mon_e.v);
        end else begin
          $display("txn %0d: res=%h c=%b z=%b n=%b v=%b", xfers, result, cout, zero, neg, ovf);
        end
      end
    end
  end

  task automatic add_vec(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic c, input logic [31:0] r, input logic ec,
                         input logic ez, input logic en, input logic ev);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.cin = c;
    v.e = '{res: r, c: ec, z: ez, n: en, v: ev};
    vecs.push_back(v);
  endtask

  // Drive a request, push its expectation at the accepting edge, return just after it.
  task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic c, input exp_t e, output int waited);
    op = o; a = va; b = vb; cin = c; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready still 0 after %0d cycles, required 1", waited);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Narrow instance: issue one request and check latency and outputs directly.
  task automatic run8(input string nm, input logic [3:0] o, input logic [7:0] va,
                      input logic [7:0] vb, input logic c, input logic [11:0] e, input int lat_exp);
    int w = 0;
    int lat = 1;
    op8 = o; a8 = va; b8 = vb; cin8 = c; in_valid8 = 1'b1;
    @(negedge clk);
    while (!in_ready8 && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(lat_exp));
    chk({nm, "_out"}, {52'd0, result8, cout8, zero8, neg8, ovf8}, {52'd0, e});
    $display("txn w8 %s: res=%h c=%b z=%b n=%b v=%b lat=%0d", nm, result8, cout8, zero8, neg8, ovf8, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   waited;
    int   lat;
    int   busy;
    int   seen;
    exp_t e;

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; cin8 = 1'b0;

    //          op      a             b             cin   result        c     z     n     v
    add_vec(OP_ADD, 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec(OP_SUB, 32'h12345678, 32'h87654321, 1'b1, 32'h8ACF1356, 1'b1, 1'b0, 1'b1, 1'b1);
    add_vec(OP_SUB, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(OP_OR,  32'h12340000, 32'h00005678, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(OP_NOT, 32'h0000FFFF, 32'h12345678, 1'b0, 32'hFFFF0000, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(4'd12,  32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(OP_SLL, 32'h80000001, 32'h00000001, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(OP_SRL, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(OP_SRL, 32'h000000F0, 32'h00000005, 1'b0, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(OP_SLL, 32'h00000001, 32'h00000020, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(OP_SRA, 32'h40000000, 32'h0000001F, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out", {out_valid, in_ready, result, cout, zero, neg, ovf},
        {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});

    // Table vectors, one request at a time.
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e, waited);
      drain();
    end

    // Single-cycle op: result visible right after the accepting edge.
    issue(OP_ADD, 32'h0000000F, 32'h00000001, 1'b0, '{32'h10, 1'b0, 1'b0, 1'b0, 1'b0}, waited);
    chk("add_latency_valid", out_valid, 1'b1);
    drain();

    // Back-to-back XOR then NOR with the consumer always ready.
    issue(OP_XOR, 32'hAAAAAAAA, 32'h55555555, 1'b0, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0}, waited);
    chk("b2b_in_ready_1", in_ready, 1'b1);
    issue(OP_NOR, 32'hAAAAAAAA, 32'h55555555, 1'b0, '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0}, waited);
    chk("b2b_no_stall", 64'(waited), 64'd0);
    chk("b2b_in_ready_2", in_ready, 1'b1);
    drain();

    // SRA by 4: four BUSY cycles, result five edges after acceptance.
    issue(OP_SRA, 32'h80000000, 32'h00000004, 1'b0, '{32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0}, waited);
    lat = 1;
    busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("sra_latency", 64'(lat), 64'd5);
    chk("sra_busy_cycles", 64'(busy), 64'd4);
    drain();

    // Backpressure: result held for five cycles, then accept on release.
    out_ready = 1'b0;
    issue(OP_ADD, 32'h00000003, 32'h00000004, 1'b0, '{32'h7, 1'b0, 1'b0, 1'b0, 1'b0}, waited);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, result, cout, zero, neg, ovf},
          {1'b1, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(OP_AND, 32'h000000FF, 32'h0000000F, 1'b0, '{32'hF, 1'b0, 1'b0, 1'b0, 1'b0}, waited);
    chk("bp_accept_on_release", 64'(waited), 64'd0);
    drain();

    // Reset on the third BUSY cycle of a long shift aborts it.
    e = '{32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
    issue(OP_SRL, 32'hFFFFFFFF, 32'h0000001F, 1'b0, e, waited);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out", {out_valid, in_ready, result, cout, zero, neg, ovf},
        {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    // Recovery after abort.
    issue(OP_XOR, 32'h0000FFFF, 32'h0000FF00, 1'b0, '{32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0}, waited);
    drain();

    // 8-bit instance: {result, cout, zero, neg, ovf}
    run8("w8_add_ovf",  OP_ADD, 8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b0, 1'b1, 1'b1}, 1);
    run8("w8_add_cin",  OP_ADD, 8'hFF, 8'h01, 1'b1, {8'h01, 1'b1, 1'b0, 1'b0, 1'b0}, 1);
    run8("w8_sub_ovf",  OP_SUB, 8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}, 1);
    run8("w8_sra3",     OP_SRA, 8'h80, 8'h03, 1'b0, {8'hF0, 1'b0, 1'b0, 1'b1, 1'b0}, 4);
    run8("w8_sll1",     OP_SLL, 8'h81, 8'h01, 1'b0, {8'h02, 1'b1, 1'b0, 1'b0, 1'b0}, 2);
    run8("w8_srl_zero", OP_SRL, 8'h81, 8'h08, 1'b0, {8'h81, 1'b0, 1'b0, 1'b1, 1'b0}, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_nbit.md
Name: alu_seq_nbit

Overview:
Parametrised sequential ALU. It replaces the fixed 32-bit combinational add/sub/logic units with one registered block behind a valid/ready handshake. ADD/SUB/AND/OR/XOR/NOR/NOT complete in one cycle. SLL/SRL/SRA run on an iterative one-bit-per-cycle shifter. The block produces status flags and sits between the decode stage and the writeback register in the datapath.

Parameters:
WIDTH, 32, operand/result width in bits (≥4, power of two)
SHW, $clog2(WIDTH), derived localparam: shift-amount width, taken from b[SHW-1:0]

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
op  in  4  opcode (see Behaviour)
a  in  WIDTH  operand A
b  in  WIDTH  operand B, or shift amount in b[SHW-1:0]
cin  in  1  carry-in for ADD, borrow-in for SUB; ignored otherwise
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
cout  out  1  carry-out / borrow-out / last bit shifted out
zero  out  1  result == 0
neg  out  1  result[WIDTH-1]
ovf  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset: state=IDLE; out_valid, result, cout, zero, neg, ovf = 0. in_ready=1 in the first cycle after reset.
- Opcodes: 0 ADD a+b+cin; 1 SUB a-b-cin; 2 AND; 3 OR; 4 XOR; 5 NOR; 6 NOT (~a, b ignored); 7 SLL; 8 SRL; 9 SRA; 10-15 give result 0 and cout/ovf 0, with zero=1.
- Accept: a request is accepted when in_valid && in_ready. Operands are captured at that edge.
- FSM IDLE: no result held.
  - Accepting a 1-cycle op goes to DONE.
  - Accepting a shift with shamt≠0 goes to BUSY.
  - Accepting a shift with shamt=0 goes to DONE with result=a, cout=0.
- FSM BUSY: shift one bit per cycle and decrement the counter. When the counter reaches 0, go to DONE.
- FSM DONE: out_valid=1 and outputs are held stable.
  - out_ready=1 with a new accept goes to DONE/BUSY per the new op.
  - out_ready=1 with no accept goes to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is always 0 in BUSY.
- Throughput: with out_ready tied high, 1-cycle ops can be issued back-to-back.
- Latency:
  - 1-cycle op accepted at edge t: out_valid=1 after edge t+1, i.e. visible in the cycle after acceptance.
  - Shift by n: out_valid rises n cycles after that, so total latency is 1+n cycles.
- ADD: cout = carry out of bit WIDTH-1. ovf = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
- SUB: cout = borrow, i.e. 1 when {a} < {b}+cin unsigned. ovf = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
- Logic/NOT: cout=0, ovf=0.
- Shifts:
  - SRA fills with the original sign bit. SLL/SRL fill with 0.
  - cout = last bit shifted out (0 when shamt=0). ovf=0.
- zero and neg are always computed from the final result. They must not glitch during BUSY; outputs only update on entering DONE.
- Backpressure: while out_valid && !out_ready, result and flags are held unchanged and no new request is accepted.
- Reset mid-operation: rst in BUSY or DONE aborts the operation. On the next edge the state is IDLE with all outputs 0. No result is emitted.
- Inputs are sampled only at the accept edge. Changes to a/b/op during BUSY have no effect.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode localparams: OP_ADD … OP_SRA.
  - FSM state encoding: IDLE/BUSY/DONE, 2 bits.
- Sub-module add_sub_nbit #(WIDTH): combinational a±b with carry/borrow-in.
  - Outputs: sum, carry/borrow-out, overflow.
  - Instanced once and selected by op.
- Shifter, FSM and flag logic live in alu_seq_nbit.

Test Plan:
1. ADD a=0x0000000F b=0x00000001 cin=0 -> result 0x00000010, cout=0, ovf=0, zero=0; out_valid exactly 1 cycle after accept. Then ADD a=0xFFFFFFFF b=0x00000001 cin=1 -> 0x00000001, cout=1, ovf=0.
2. SUB a=0x12345678 b=0x87654321 cin=1 -> 0x8ACF1356, cout=1, ovf=1, neg=1.
3. Back-to-back, out_ready=1: XOR 0xAAAAAAAA^0x55555555 -> 0xFFFFFFFF, neg=1. Next cycle NOR of the same operands -> 0x00000000, zero=1. in_ready stays high throughout.
4. Shifts:
   - SRA a=0x80000000 shamt=4 -> 0xF8000000, cout=0, out_valid 5 cycles after accept, in_ready=0 for 4 cycles.
   - SLL a=0x80000001 shamt=1 -> 0x00000002, cout=1.
   - SRL shamt=0 -> result=a after 1 cycle.
5. Backpressure: hold out_ready=0 for 5 cycles after an ADD result. result/flags stay stable and in_ready=0. Raise out_ready with in_valid -> the new request is accepted that edge.
6. Reset: SRL a=0xFFFFFFFF shamt=31, assert rst on the 3rd BUSY cycle -> next cycle out_valid=0, all outputs 0, in_ready=1. Repeat scenarios 1 and 4 with WIDTH=8, e.g. ADD 0x7F+0x01 -> 0x80, ovf=1.
